// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch / load-store memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned PORT_IF = 0;
    localparam int unsigned PORT_D  = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle of the memory port arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 10
);
    logic              if_req;
    logic [AWIDTH-1:0] if_addr;
    logic              if_ack;
    logic [DWIDTH-1:0] if_rdata;
    logic              if_err;

    logic              d_req;
    logic              d_we;
    logic [AWIDTH-1:0] d_addr;
    logic [DWIDTH-1:0] d_wdata;
    logic              d_ack;
    logic [DWIDTH-1:0] d_rdata;
    logic              d_err;

    logic [AWIDTH-1:0] mem_addr;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;

    logic              busy;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
               mem_addr, mem_rd_en, mem_wr_en, mem_wdata, busy
    );

    // Core and memory side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
               mem_addr, mem_rd_en, mem_wr_en, mem_wdata, busy
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the last-grant history is held by the parent.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       grant_en,
    output logic [1:0] grant
);

    // last_grant = 1 means the data port won the previous arbitration
    always_comb begin
        grant = '0;
        if (grant_en) begin
            if (req[PORT_IF] && req[PORT_D]) begin
                if (last_grant) begin
                    grant[PORT_IF] = 1'b1;
                end else begin
                    grant[PORT_D] = 1'b1;
                end
            end else begin
                grant = req;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the load/store
// unit: round-robin grant, multi-cycle read wait, one-cycle acknowledge.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned AWIDTH      = 10,
    parameter int unsigned MEM_DEPTH   = 1000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    state_e              r_state,        w_state_nxt;
    logic                r_last_grant,   w_last_grant_nxt;
    logic                r_gnt_d,        w_gnt_d_nxt;
    logic [CNT_W-1:0]    r_cnt,          w_cnt_nxt;
    logic                r_if_ack,       w_if_ack_nxt;
    logic                r_if_err,       w_if_err_nxt;
    logic [DWIDTH-1:0]   r_if_rdata,     w_if_rdata_nxt;
    logic                r_d_ack,        w_d_ack_nxt;
    logic                r_d_err,        w_d_err_nxt;
    logic [DWIDTH-1:0]   r_d_rdata,      w_d_rdata_nxt;
    logic [AWIDTH-1:0]   r_mem_addr,     w_mem_addr_nxt;
    logic                r_mem_rd_en,    w_mem_rd_en_nxt;
    logic                r_mem_wr_en,    w_mem_wr_en_nxt;
    logic [DWIDTH-1:0]   r_mem_wdata,    w_mem_wdata_nxt;
    logic                r_busy,         w_busy_nxt;

    logic [1:0]          w_grant;
    logic                w_grant_en;
    logic                w_sel_d;
    logic [AWIDTH-1:0]   w_sel_addr;
    logic                w_sel_we;
    logic                w_sel_oor;

    assign w_grant_en = (r_state == IDLE);

    rr_arb2 u_rr_arb2 (
        .req        ({bus.d_req, bus.if_req}),
        .last_grant (r_last_grant),
        .grant_en   (w_grant_en),
        .grant      (w_grant)
    );

    // Request selected by the current grant
    assign w_sel_d    = w_grant[PORT_D];
    assign w_sel_addr = w_sel_d ? bus.d_addr : bus.if_addr;
    assign w_sel_we   = w_sel_d & bus.d_we;
    assign w_sel_oor  = (32'(w_sel_addr) >= MEM_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_gnt_d      <= 1'b0;
            r_cnt        <= '0;
            r_if_ack     <= 1'b0;
            r_if_err     <= 1'b0;
            r_if_rdata   <= '0;
            r_d_ack      <= 1'b0;
            r_d_err      <= 1'b0;
            r_d_rdata    <= '0;
            r_mem_addr   <= '0;
            r_mem_rd_en  <= 1'b0;
            r_mem_wr_en  <= 1'b0;
            r_mem_wdata  <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_gnt_d      <= w_gnt_d_nxt;
            r_cnt        <= w_cnt_nxt;
            r_if_ack     <= w_if_ack_nxt;
            r_if_err     <= w_if_err_nxt;
            r_if_rdata   <= w_if_rdata_nxt;
            r_d_ack      <= w_d_ack_nxt;
            r_d_err      <= w_d_err_nxt;
            r_d_rdata    <= w_d_rdata_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_rd_en  <= w_mem_rd_en_nxt;
            r_mem_wr_en  <= w_mem_wr_en_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_gnt_d_nxt      = r_gnt_d;
        w_cnt_nxt        = r_cnt;
        w_if_ack_nxt     = 1'b0;
        w_if_err_nxt     = 1'b0;
        w_if_rdata_nxt   = r_if_rdata;
        w_d_ack_nxt      = 1'b0;
        w_d_err_nxt      = 1'b0;
        w_d_rdata_nxt    = r_d_rdata;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_rd_en_nxt  = r_mem_rd_en;
        w_mem_wr_en_nxt  = r_mem_wr_en;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_busy_nxt       = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (|w_grant) begin
                    w_last_grant_nxt = w_sel_d;
                    w_gnt_d_nxt      = w_sel_d;
                    // Out-of-range: no memory cycle, answer with an error
                    if (w_sel_oor) begin
                        w_state_nxt = DONE;
                        if (w_sel_d) begin
                            w_d_ack_nxt   = 1'b1;
                            w_d_err_nxt   = 1'b1;
                            w_d_rdata_nxt = '0;
                        end else begin
                            w_if_ack_nxt   = 1'b1;
                            w_if_err_nxt   = 1'b1;
                            w_if_rdata_nxt = '0;
                        end
                    end else if (w_sel_we) begin
                        w_mem_addr_nxt  = w_sel_addr;
                        w_mem_wdata_nxt = bus.d_wdata;
                        w_mem_wr_en_nxt = 1'b1;
                        w_state_nxt     = WR;
                    end else begin
                        w_mem_addr_nxt  = w_sel_addr;
                        w_mem_rd_en_nxt = 1'b1;
                        w_cnt_nxt       = WAIT_LD;
                        w_state_nxt     = RD;
                    end
                end
            end

            RD: begin
                if (r_cnt == '0) begin
                    w_mem_rd_en_nxt = 1'b0;
                    w_state_nxt     = DONE;
                    if (r_gnt_d) begin
                        w_d_ack_nxt   = 1'b1;
                        w_d_rdata_nxt = bus.mem_rdata;
                    end else begin
                        w_if_ack_nxt   = 1'b1;
                        w_if_rdata_nxt = bus.mem_rdata;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            WR: begin
                w_mem_wr_en_nxt = 1'b0;
                w_state_nxt     = DONE;
                if (r_gnt_d) begin
                    w_d_ack_nxt = 1'b1;
                end else begin
                    w_if_ack_nxt = 1'b1;
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    assign bus.if_ack    = r_if_ack;
    assign bus.if_err    = r_if_err;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_ack     = r_d_ack;
    assign bus.d_err     = r_d_err;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_rd_en = r_mem_rd_en;
    assign bus.mem_wr_en = r_mem_wr_en;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = r_busy;

endmodule
